// File: rtl/fft_bitrev_buffer_pkg.sv
// Shared defaults and reader state encoding for the FFT bit-reversal reorder buffer.
package fft_bitrev_buffer_pkg;

    localparam int FFT_N      = 16;
    localparam int FFT_NLOG2  = 4;
    localparam int FFT_X_WDTH = 16;
    localparam int FFT_M_WDTH = 3;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

endpackage

// File: rtl/fft_bitrev_buffer_if.sv
// Streaming sample bundle between the FFT core, the reorder buffer and its consumer.
// Build macro FFT_BITREV_BYPASS_EN adds the in_bypass request bit.
interface fft_bitrev_buffer_if
    import fft_bitrev_buffer_pkg::*;
#(
    parameter int X_WDTH = FFT_X_WDTH,
    parameter int M_WDTH = FFT_M_WDTH
) ();

    logic [2*X_WDTH-1:0] in_data;
    logic                in_nd;
    logic [M_WDTH-1:0]   in_m;
    logic                in_first;
    logic [2*X_WDTH-1:0] out_data;
    logic                out_nd;
    logic [M_WDTH-1:0]   out_m;
    logic                out_first;
    logic                error;

`ifdef FFT_BITREV_BYPASS_EN
    logic                in_bypass;

    modport master (
        output in_data, in_nd, in_m, in_first, in_bypass,
        input  out_data, out_nd, out_m, out_first, error
    );

    modport slave (
        input  in_data, in_nd, in_m, in_first, in_bypass,
        output out_data, out_nd, out_m, out_first, error
    );
`else
    modport master (
        output in_data, in_nd, in_m, in_first,
        input  out_data, out_nd, out_m, out_first, error
    );

    modport slave (
        input  in_data, in_nd, in_m, in_first,
        output out_data, out_nd, out_m, out_first, error
    );
`endif

endinterface

// File: rtl/fft_bitrev_ram.sv
// Simple dual-port RAM, one write port and one registered read port (one-cycle latency).
module fft_bitrev_ram
    import fft_bitrev_buffer_pkg::*;
#(
    parameter int DW = 2*FFT_X_WDTH + FFT_M_WDTH,
    parameter int AW = FFT_NLOG2 + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array itself is never reset; which entries are meaningful is tracked by the bank full flags.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong reorder buffer turning bit-reversed FFT frames into natural order, with frame-alignment checking.
// Build macro FFT_BITREV_BYPASS_EN adds in_bypass: frames flagged on their first sample pass through in input order.
module fft_bitrev_buffer
    import fft_bitrev_buffer_pkg::*;
#(
    parameter int N      = FFT_N,
    parameter int NLOG2  = FFT_NLOG2,
    parameter int X_WDTH = FFT_X_WDTH,
    parameter int M_WDTH = FFT_M_WDTH
) (
    input logic                clk,
    input logic                rst,
    fft_bitrev_buffer_if.slave bus
);

    localparam int               AW       = NLOG2 + 1;
    localparam int               DW       = 2*X_WDTH + M_WDTH;
    localparam logic [NLOG2-1:0] LAST_IDX = NLOG2'(N - 1);

    function automatic logic [NLOG2-1:0] bitrev(input logic [NLOG2-1:0] v);
        logic [NLOG2-1:0] r;
        for (int i = 0; i < NLOG2; i++) begin
            r[i] = v[NLOG2-1-i];
        end
        return r;
    endfunction

    // Write side
    logic [NLOG2-1:0] wr_cnt;
    logic [NLOG2-1:0] wr_idx;
    logic             wr_bank;
    logic             wr_en;
    logic             wr_done;
    logic             resync;
    logic             drop;
    logic [AW-1:0]    wr_addr;
    logic [1:0]       full;
    logic             error_q;
`ifdef FFT_BITREV_BYPASS_EN
    logic             bypass_q;
    logic             bypass_now;
`endif

    // Read side
    rd_state_e        state;
    rd_state_e        state_nxt;
    logic [NLOG2-1:0] rd_cnt;
    logic [NLOG2-1:0] rd_cnt_nxt;
    logic             rd_bank;
    logic             rd_bank_nxt;
    logic             rd_en;
    logic             rd_last;
    logic             other_ready;
    logic             out_nd_q;
    logic             out_first_q;
    logic [DW-1:0]    rd_data;

    // A first marker mid-frame restarts the frame at index 0; a non-first sample at index 0 is dropped.
    always_comb begin
        resync  = bus.in_nd && bus.in_first && (wr_cnt != '0);
        drop    = bus.in_nd && !bus.in_first && (wr_cnt == '0);
        wr_en   = bus.in_nd && !drop;
        wr_idx  = resync ? '0 : wr_cnt;
        wr_done = wr_en && (wr_idx == LAST_IDX);
`ifdef FFT_BITREV_BYPASS_EN
        bypass_now = bus.in_first ? bus.in_bypass : bypass_q;
        wr_addr    = {wr_bank, (bypass_now ? wr_idx : bitrev(wr_idx))};
`else
        wr_addr    = {wr_bank, bitrev(wr_idx)};
`endif
    end

    // NOTE: all state updates are non-blocking, so the full-flag set below wins over an earlier clear of the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            full     <= '0;
            error_q  <= 1'b0;
`ifdef FFT_BITREV_BYPASS_EN
            bypass_q <= 1'b0;
`endif
        end else begin
            if (resync || drop) begin
                error_q <= 1'b1;
            end
            if (wr_en) begin
                wr_cnt <= wr_idx + 1'b1;
            end
`ifdef FFT_BITREV_BYPASS_EN
            if (wr_en && bus.in_first) begin
                bypass_q <= bus.in_bypass;
            end
`endif
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
            if (rd_last) begin
                full[rd_bank] <= 1'b0;
            end
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RD_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_cnt  <= rd_cnt_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    // A bank completing this very cycle counts as ready, which keeps back-to-back frames gapless.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_nxt   = state;
        rd_cnt_nxt  = rd_cnt;
        rd_bank_nxt = rd_bank;
        rd_en       = 1'b0;
        rd_last     = 1'b0;
        other_ready = full[~rd_bank] || (wr_done && (wr_bank != rd_bank));
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    rd_en      = 1'b1;
                    rd_cnt_nxt = rd_cnt + 1'b1;
                    state_nxt  = RD_READ;
                end
            end
            RD_READ: begin
                rd_en      = 1'b1;
                rd_cnt_nxt = rd_cnt + 1'b1;
                if (rd_cnt == LAST_IDX) begin
                    rd_last     = 1'b1;
                    rd_bank_nxt = ~rd_bank;
                    state_nxt   = other_ready ? RD_READ : RD_IDLE;
                end
            end
            default: begin
                state_nxt = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_nd_q    <= 1'b0;
            out_first_q <= 1'b0;
        end else begin
            out_nd_q    <= rd_en;
            out_first_q <= rd_en && (rd_cnt == '0);
        end
    end

    fft_bitrev_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata ({bus.in_data, bus.in_m}),
        .re    (rd_en),
        .raddr ({rd_bank, rd_cnt}),
        .rdata (rd_data)
    );

    assign bus.out_data  = rd_data[DW-1:M_WDTH];
    assign bus.out_m     = rd_data[M_WDTH-1:0];
    assign bus.out_nd    = out_nd_q;
    assign bus.out_first = out_first_q;
    assign bus.error     = error_q;

endmodule
